if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0000, instruction word presented downstream when no valid entry exists.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 SHALL have port if_valid  input  1  fetch stage presents a valid fetched instruction this cycle.
REQ-005 SHALL have port pc_plus4  input  32  PC+4 value of the fetched instruction (fetch adder output).
REQ-006 SHALL have port instruction  input  32  fetched instruction word.
REQ-007 SHALL have port flush  input  1  branch/jump taken; discard all buffered and incoming fetches.
REQ-008 SHALL have port id_ready  input  1  decode stage accepts the head entry this cycle.
REQ-009 SHALL have port if_ready  output  1  buffer can accept a fetch this cycle; deasserted value stalls the PC register.
REQ-010 SHALL have port id_valid  output  1  head entry valid for decode.
REQ-011 SHALL have port id_pc_plus4  output  32  PC+4 of head entry.
REQ-012 SHALL have port id_instruction  output  32  instruction of head entry.
REQ-013 SHALL have port occupancy  output  2  number of valid entries, 0..2.

Function
REQ-014 SHALL be a 2-entry FIFO of {pc_plus4, instruction} pairs with 1-bit read and write pointers wrapping 1->0.
REQ-015 SHALL perform a push when if_valid=1 and if_ready=1 at the rising edge, writing the entry at the write pointer.
REQ-016 SHALL perform a pop when id_valid=1 and id_ready=1 at the rising edge, advancing the read pointer.
REQ-017 SHALL drive if_ready = (occupancy < 2), combinational from occupancy only (no dependence on id_ready).
REQ-018 SHALL drive id_valid = (occupancy != 0).
REQ-019 SHALL drive id_pc_plus4/id_instruction from the entry at the read pointer when id_valid=1; otherwise 32'h0 and NOP_INSTR.
REQ-020 SHALL update occupancy per cycle: push only +1, pop only -1, push and pop together unchanged, neither unchanged.
REQ-021 SHALL at occupancy 0 with simultaneous if_valid and id_ready perform push only (no bypass); entry appears on outputs next cycle, latency exactly 1 cycle.
REQ-022 SHALL at occupancy 2 ignore if_valid (if_ready=0); a pop that cycle leaves occupancy 1 and if_ready=1 next cycle.
REQ-023 SHALL on flush=1 at a rising edge set occupancy to 0 and both pointers to 0, discarding any same-cycle push and pop; flush has priority over all other events.
REQ-024 SHALL never underflow or overflow: pop at occupancy 0 and push at occupancy 2 are no-ops.
REQ-025 SHALL preserve FIFO order: entries leave in the order accepted, including across pointer wrap-around.
REQ-026 SHALL hold stored entry contents unchanged while id_ready=0 (decode stall).

Reset
REQ-027 SHALL, while rst=0, immediately (asynchronously) force occupancy=0, pointers=0, entry storage to {32'h0, NOP_INSTR}; hence if_ready=1, id_valid=0, id_pc_plus4=0, id_instruction=NOP_INSTR.
REQ-028 SHALL resume normal operation on the first rising edge after rst returns to 1; reset asserted mid-operation discards all entries.

Verification
REQ-029 Reset: rst=0 with occupancy 2 mid-cycle -> outputs go to if_ready=1, id_valid=0, id_instruction=32'h0 without a clock edge.
REQ-030 Streaming: id_ready=1, push 0x2002_0004/pc 0x4, 0x2003_0008/pc 0x8 on consecutive cycles -> each appears on id_* exactly one cycle later, in order, occupancy stays 1.
REQ-031 Stall fill: id_ready=0, push A, B, C on three cycles -> occupancy 2, if_ready=0 after second push, C not stored; id_ready=1 then yields A, B in order.
REQ-032 Wrap-around: alternate push/pop for 5 cycles after filling to 1 -> order preserved across read/write pointer wrap, no lost or duplicated entry.
REQ-033 Flush: occupancy 2 with if_valid=1, id_ready=1, flush=1 -> next cycle occupancy 0, id_valid=0, id_instruction=NOP_INSTR, incoming entry dropped.
REQ-034 Simultaneous at full: occupancy 2, id_ready=1, if_valid=1 -> pop only, occupancy 1, incoming not accepted, if_ready=1 next cycle.

Source files
------------

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: 2-entry FIFO of {pc_plus4, instruction} between fetch
// and decode. Push happens on if_valid & if_ready, pop on id_valid & id_ready.
// A push into an empty buffer is not bypassed, so an entry always shows up on
// the outputs one cycle after it is accepted. Flush overrides every other event.
module if_id_buffer #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instruction,
  input  logic        flush,
  input  logic        id_ready,
  output logic        if_ready,
  output logic        id_valid,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instruction,
  output logic [1:0]  occupancy
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t [1:0] mem_q, mem_d;
  logic       wptr_q, wptr_d;
  logic       rptr_q, rptr_d;
  logic [1:0] occ_q, occ_d;
  logic       push, pop;
  ent_t       head;

  // Handshakes and head-of-queue outputs
  always_comb begin
    if_ready       = (occ_q < 2'd2);
    id_valid       = (occ_q != 2'd0);
    push           = if_valid & if_ready;
    pop            = id_valid & id_ready;
    head           = mem_q[rptr_q];
    id_pc_plus4    = id_valid ? head.pc  : 32'h0;
    id_instruction = id_valid ? head.ins : NOP_INSTR;
    occupancy      = occ_q;
  end

  // Next-state: flush clears pointers and count but leaves storage alone,
  // since stale storage is masked by id_valid=0
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (flush) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      occ_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = '{pc: pc_plus4, ins: instruction};
        wptr_d        = ~wptr_q;
      end
      if (pop) rptr_d = ~rptr_q;
      case ({push, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= {2{ent_t'{pc: 32'h0, ins: NOP_INSTR}}};
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, streaming, stall fill, wrap-around,
// flush, simultaneous push/pop at full, and asynchronous mid-operation reset.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] pc_plus4;
  logic [31:0] instruction;
  logic        flush;
  logic        id_ready;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instruction;
  logic [1:0]  occupancy;

  int total  = 0;
  int passed = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  if_id_buffer #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .pc_plus4(pc_plus4),
    .instruction(instruction), .flush(flush), .id_ready(id_ready),
    .if_ready(if_ready), .id_valid(id_valid), .id_pc_plus4(id_pc_plus4),
    .id_instruction(id_instruction), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Check all outputs at once
  task automatic chk_all(input string tag, input logic [1:0] occ, input logic ir,
                         input logic iv, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".occ"}, 32'(occupancy), 32'(occ));
    chk({tag, ".if_ready"}, 32'(if_ready), 32'(ir));
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(iv));
    chk({tag, ".pc"}, id_pc_plus4, pc);
    chk({tag, ".ins"}, id_instruction, ins);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    if_valid = v; pc_plus4 = pc; instruction = ins; id_ready = rdy; flush = fl;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    #3;
    chk_all("reset", 2'd0, 1, 0, 32'h0, NOP);
    tick();
    rst = 1'b1;
    tick();
    chk_all("post_reset", 2'd0, 1, 0, 32'h0, NOP);

    // Streaming: each entry visible one cycle after push, occupancy stays 1
    drive(1, 32'h4, 32'h2002_0004, 1, 0);
    tick();
    chk_all("stream0", 2'd1, 1, 1, 32'h4, 32'h2002_0004);
    drive(1, 32'h8, 32'h2003_0008, 1, 0);
    tick();
    chk_all("stream1", 2'd1, 1, 1, 32'h8, 32'h2003_0008);
    drive(0, 0, 0, 1, 0);
    tick();
    chk_all("stream_drain", 2'd0, 1, 0, 32'h0, NOP);
    tick();
    chk_all("pop_empty_noop", 2'd0, 1, 0, 32'h0, NOP);

    // Stall fill: C offered at full is not stored
    drive(1, 32'h10, 32'hAAAA_0001, 0, 0);
    tick();
    chk_all("fill_a", 2'd1, 1, 1, 32'h10, 32'hAAAA_0001);
    drive(1, 32'h14, 32'hBBBB_0002, 0, 0);
    tick();
    chk_all("fill_b", 2'd2, 0, 1, 32'h10, 32'hAAAA_0001);
    drive(1, 32'h18, 32'hCCCC_0003, 0, 0);
    tick();
    chk_all("fill_c_drop", 2'd2, 0, 1, 32'h10, 32'hAAAA_0001);
    drive(0, 0, 0, 1, 0);
    tick();
    chk_all("drain_b", 2'd1, 1, 1, 32'h14, 32'hBBBB_0002);
    tick();
    chk_all("drain_empty", 2'd0, 1, 0, 32'h0, NOP);

    // Wrap-around: fill to 1, then push+pop every cycle for 5 cycles
    drive(1, 32'h100, 32'h5000_0000, 0, 0);
    tick();
    chk_all("wrap_fill", 2'd1, 1, 1, 32'h100, 32'h5000_0000);
    for (int i = 1; i <= 5; i++) begin
      drive(1, 32'h100 + 32'(i * 4), 32'h5000_0000 + 32'(i), 1, 0);
      tick();
      chk_all($sformatf("wrap%0d", i), 2'd1, 1, 1, 32'h100 + 32'(i * 4), 32'h5000_0000 + 32'(i));
    end
    drive(0, 0, 0, 1, 0);
    tick();
    chk_all("wrap_drain", 2'd0, 1, 0, 32'h0, NOP);

    // Flush at full with push and pop offered
    drive(1, 32'h200, 32'hF000_0000, 0, 0);
    tick();
    drive(1, 32'h204, 32'hF000_0001, 0, 0);
    tick();
    chk_all("flush_full", 2'd2, 0, 1, 32'h200, 32'hF000_0000);
    drive(1, 32'h208, 32'hF000_0002, 1, 1);
    tick();
    chk_all("flush", 2'd0, 1, 0, 32'h0, NOP);
    drive(0, 0, 0, 1, 0);
    tick();
    chk_all("flush_after", 2'd0, 1, 0, 32'h0, NOP);

    // Simultaneous push and pop at full: pop only
    drive(1, 32'h300, 32'h6000_0000, 0, 0);
    tick();
    drive(1, 32'h304, 32'h6000_0001, 0, 0);
    tick();
    drive(1, 32'h308, 32'h6000_0002, 1, 0);
    tick();
    chk_all("full_pp", 2'd1, 1, 1, 32'h304, 32'h6000_0001);
    drive(0, 0, 0, 1, 0);
    tick();
    chk_all("full_pp_drain", 2'd0, 1, 0, 32'h0, NOP);

    // Asynchronous reset mid-operation at occupancy 2
    drive(1, 32'h400, 32'h7000_0000, 0, 0);
    tick();
    drive(1, 32'h404, 32'h7000_0001, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("pre_areset.occ", 32'(occupancy), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk_all("areset", 2'd0, 1, 0, 32'h0, NOP);
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 1, 0);
    tick();
    chk_all("areset_after", 2'd0, 1, 0, 32'h0, NOP);
    drive(1, 32'h500, 32'h8000_0000, 1, 0);
    tick();
    chk_all("resume", 2'd1, 1, 1, 32'h500, 32'h8000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
